execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- Pipeline stage directly upstream of the memory stage.
- Takes decoded operands and control from decode, computes the 24-bit ALU result or effective address, and registers everything the memory stage consumes.
- Contains a sequential shift-add multiplier. While the multiplier runs, the stage stalls the front end and sends bubbles downstream.

Parameters:
- DATA_W, 24, operand/result width; also the number of multiplier iterations.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- en  input  1  pipeline advance enable from hazard control; low freezes all state
- opType  input  2  instruction class: 00 ALU, 01 memory, 10 load-immediate, 11 bubble/nop
- opCode  input  4  operation within class
- memWrite, memToReg, regWrite  input  1 each  decoded control
- Rc  input  4  destination register
- srcA, srcB  input  24 each  operands (srcB is register or immediate, already selected)
- storeData  input  24  data for stores
- stall  output  1  high = upstream must hold its current instruction
- exOpType  output  2  registered opType
- exOpCode  output  4  registered opCode
- exMemWrite, exMemToReg, exRegWrite  output  1 each  registered control
- exRc  output  4  registered destination
- aluResult  output  24  result, or address for opType 01
- writeData  output  24  registered storeData
- zeroFlag  output  1  aluResult == 0

Behaviour:
- Reset (rst=1 at edge, priority over en):
  - All outputs 0; zeroFlag = 1.
  - FSM goes to IDLE, iteration counter 0, stall = 0.
  - A multiply in progress is abandoned; no result is produced.
- en=0: output register, FSM, counter and multiplier regs all hold. stall holds its value.
- FSM states: IDLE, MUL_RUN.
- IDLE, en=1, instruction is not MUL:
  - Output register loads the computed result plus control fields at the next edge.
  - Latency is 1 cycle. stall = 0.
- ALU ops (opType 00), all 24-bit modulo 2^24 with no carry output:
  - 0 ADD: A+B
  - 1 SUB: A-B
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SLL: A<<B[4:0]
  - 6 SRL: A>>B[4:0], logical
  - 7 MUL: sequential, see below
  - 8 MOV: B
  - 9–15: result 0, and exRegWrite/exMemWrite forced 0.
  - Shift amounts of 24 to 31 yield 0.
- opType 01: aluResult = srcA+srcB; control passes through; writeData = storeData.
- opType 10: aluResult = srcB.
- opType 11: bubble. All control outputs 0, aluResult 0.
- MUL (opType 00, opCode 7), accepted from IDLE with en=1:
  - Capture srcA, srcB, Rc, regWrite and opCode into internal regs.
  - Counter = 0, accumulator = 0, state goes to MUL_RUN.
  - Output register loads a bubble at the same edge.
- MUL_RUN, each en=1 edge:
  - If mA[0], acc += mB.
  - mA >>= 1; mB <<= 1 (truncated to 24 bits); counter++.
  - Output register keeps loading a bubble.
- MUL_RUN, at the edge where counter == DATA_W-1:
  - Output register loads the final acc with the captured control fields (lower 24 bits of A*B).
  - State returns to IDLE.
- stall = (state == MUL_RUN), combinational from state. It stays high through the final iteration cycle. Instructions presented while stalled are ignored and must be held by upstream.
- MUL result is visible DATA_W+1 = 25 edges after acceptance. stall is high for exactly DATA_W = 24 cycles with en continuously high.
- zeroFlag is registered together with aluResult. It is 1 for bubbles.
- Back-to-back MULs: the second one is accepted in the first IDLE cycle after the first completes.

Test Plan:
- Reset, then ADD srcA=0x00000F, srcB=0x000001, Rc=3, regWrite=1 → next cycle aluResult=0x000010, exRc=3, exRegWrite=1, zeroFlag=0.
- SUB 5−5 → aluResult=0, zeroFlag=1. SLL 0x000001 by 23 → 0x800000. SRL by 24 → 0. ADD 0xFFFFFF+1 → 0 (wrap).
- MUL srcA=0x000123, srcB=0x000045 with en=1 → stall high for cycles 1–24, bubbles on outputs during that time, aluResult=0x004E6F at edge 25. MUL 0xFFFFFF×0xFFFFFF → 0x000001.
- MUL with en dropped for 5 cycles mid-run → result delayed exactly 5 cycles with the value unchanged; stall stays high throughout.
- rst asserted at iteration 10 of a MUL → next cycle all outputs 0, stall 0. A following ADD completes normally in 1 cycle.
- opType 01 with srcA=0x000100, srcB=0x000004, storeData=0x00ABCD, memWrite=1 → aluResult=0x000104, writeData=0x00ABCD, exMemWrite=1. opType 11 → all control outputs 0.

Source files
------------

// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
//  Module      : execute_stage
//  Description : Execute pipeline stage sitting directly ahead of the memory
//                stage. It computes the ALU result or the effective address
//                from decoded operands and registers the control fields the
//                memory stage consumes. A multi-cycle shift-add multiplier is
//                built in. While it runs, the stage stalls the front end and
//                issues bubbles downstream.
//
//  Ports       : clk, rst                       clock, sync active-high reset
//                en                             advance enable (low = freeze)
//                opType, opCode                 instruction class / operation
//                memWrite, memToReg, regWrite   decoded control
//                Rc                             destination register
//                srcA, srcB                     operands
//                storeData                      store data
//                stall                          upstream must hold instruction
//                exOpType .. writeData          registered outputs
//                zeroFlag                       registered (aluResult == 0)
//  Revision    : 1.0  initial release
// ============================================================================
module execute_stage #(
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        opType,
    input  logic [3:0]        opCode,
    input  logic              memWrite,
    input  logic              memToReg,
    input  logic              regWrite,
    input  logic [3:0]        Rc,
    input  logic [DATA_W-1:0] srcA,
    input  logic [DATA_W-1:0] srcB,
    input  logic [DATA_W-1:0] storeData,
    output logic              stall,
    output logic [1:0]        exOpType,
    output logic [3:0]        exOpCode,
    output logic              exMemWrite,
    output logic              exMemToReg,
    output logic              exRegWrite,
    output logic [3:0]        exRc,
    output logic [DATA_W-1:0] aluResult,
    output logic [DATA_W-1:0] writeData,
    output logic              zeroFlag
);

    localparam int CNT_W = $clog2(DATA_W);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_MUL_RUN = 1'b1;

    localparam logic [1:0] TYPE_ALU = 2'b00;
    localparam logic [1:0] TYPE_MEM = 2'b01;
    localparam logic [1:0] TYPE_LI  = 2'b10;
    localparam logic [1:0] TYPE_NOP = 2'b11;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_MUL = 4'd7;
    localparam logic [3:0] OP_MOV = 4'd8;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]        state;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] mul_a;
    logic [DATA_W-1:0] mul_b;
    logic [DATA_W-1:0] acc;
    logic [3:0]        mul_rc;
    logic              mul_rw;
    logic [3:0]        mul_op;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic              is_mul;
    logic              last_iter;
    logic [DATA_W-1:0] acc_next;
    logic [4:0]        shamt;

    logic [DATA_W-1:0] dec_result;
    logic              dec_rw;
    logic              dec_mw;
    logic              dec_mtr;
    logic [DATA_W-1:0] dec_wd;

    logic [1:0]        nxt_type;
    logic [3:0]        nxt_op;
    logic              nxt_mw;
    logic              nxt_mtr;
    logic              nxt_rw;
    logic [3:0]        nxt_rc;
    logic [DATA_W-1:0] nxt_alu;
    logic [DATA_W-1:0] nxt_wd;
    logic [0:0]        nxt_state;

    assign is_mul    = (opType == TYPE_ALU) && (opCode == OP_MUL);
    assign last_iter = (count == CNT_W'(DATA_W - 1));
    // The final iteration's partial product must be folded into the result
    // written out on that same edge, so the output path uses acc_next.
    assign acc_next  = mul_a[0] ? (acc + mul_b) : acc;
    assign shamt     = srcB[4:0];
    assign stall     = (state == S_MUL_RUN);

    // Decode of a single-cycle instruction
    always_comb begin
        dec_result = '0;
        dec_rw     = regWrite;
        dec_mw     = memWrite;
        dec_mtr    = memToReg;
        dec_wd     = storeData;
        case (opType)
            TYPE_ALU: begin
                case (opCode)
                    OP_ADD: dec_result = srcA + srcB;
                    OP_SUB: dec_result = srcA - srcB;
                    OP_AND: dec_result = srcA & srcB;
                    OP_OR:  dec_result = srcA | srcB;
                    OP_XOR: dec_result = srcA ^ srcB;
                    OP_SLL: dec_result = (shamt >= 5'(DATA_W)) ? '0 : (srcA << shamt);
                    OP_SRL: dec_result = (shamt >= 5'(DATA_W)) ? '0 : (srcA >> shamt);
                    OP_MUL: dec_result = '0;
                    OP_MOV: dec_result = srcB;
                    default: begin
                        // Undefined operations must not corrupt architectural state
                        dec_result = '0;
                        dec_rw     = 1'b0;
                        dec_mw     = 1'b0;
                    end
                endcase
            end
            TYPE_MEM: dec_result = srcA + srcB;
            TYPE_LI:  dec_result = srcB;
            default: begin
                dec_result = '0;
                dec_rw     = 1'b0;
                dec_mw     = 1'b0;
                dec_mtr    = 1'b0;
                dec_wd     = '0;
            end
        endcase
    end

    // Next output-register contents and next FSM state. Defaults describe a
    // bubble, which is what goes downstream whenever the multiplier is busy.
    always_comb begin
        nxt_type  = TYPE_NOP;
        nxt_op    = 4'd0;
        nxt_mw    = 1'b0;
        nxt_mtr   = 1'b0;
        nxt_rw    = 1'b0;
        nxt_rc    = 4'd0;
        nxt_alu   = '0;
        nxt_wd    = '0;
        nxt_state = state;
        case (state)
            S_IDLE: begin
                if (is_mul) begin
                    nxt_state = S_MUL_RUN;
                end else begin
                    nxt_type = opType;
                    nxt_op   = opCode;
                    nxt_mw   = dec_mw;
                    nxt_mtr  = dec_mtr;
                    nxt_rw   = dec_rw;
                    nxt_rc   = Rc;
                    nxt_alu  = dec_result;
                    nxt_wd   = dec_wd;
                end
            end
            S_MUL_RUN: begin
                if (last_iter) begin
                    nxt_state = S_IDLE;
                    nxt_type  = TYPE_ALU;
                    nxt_op    = mul_op;
                    nxt_rw    = mul_rw;
                    nxt_rc    = mul_rc;
                    nxt_alu   = acc_next;
                end
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            exOpType   <= 2'b00;
            exOpCode   <= 4'd0;
            exMemWrite <= 1'b0;
            exMemToReg <= 1'b0;
            exRegWrite <= 1'b0;
            exRc       <= 4'd0;
            aluResult  <= '0;
            writeData  <= '0;
            zeroFlag   <= 1'b1;
        end else if (en) begin
            exOpType   <= nxt_type;
            exOpCode   <= nxt_op;
            exMemWrite <= nxt_mw;
            exMemToReg <= nxt_mtr;
            exRegWrite <= nxt_rw;
            exRc       <= nxt_rc;
            aluResult  <= nxt_alu;
            writeData  <= nxt_wd;
            zeroFlag   <= (nxt_alu == '0);
        end
    end

    // ------------------------------------------------------------------
    // FSM and shift-add multiplier
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            count  <= '0;
            mul_a  <= '0;
            mul_b  <= '0;
            acc    <= '0;
            mul_rc <= 4'd0;
            mul_rw <= 1'b0;
            mul_op <= 4'd0;
        end else if (en) begin
            state <= nxt_state;
            case (state)
                S_IDLE: begin
                    if (is_mul) begin
                        mul_a  <= srcA;
                        mul_b  <= srcB;
                        mul_rc <= Rc;
                        mul_rw <= regWrite;
                        mul_op <= opCode;
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                S_MUL_RUN: begin
                    acc   <= acc_next;
                    mul_a <= mul_a >> 1;
                    mul_b <= mul_b << 1;
                    count <= count + CNT_W'(1);
                end
                default: count <= '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_execute_stage
//  Description : Scoreboard bench for execute_stage. The stimulus process
//                pushes one expected output snapshot per clock edge; an
//                independent monitor pops and compares after every edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  opType;
    logic [3:0]  opCode;
    logic        memWrite, memToReg, regWrite;
    logic [3:0]  Rc;
    logic [23:0] srcA, srcB, storeData;
    logic        stall;
    logic [1:0]  exOpType;
    logic [3:0]  exOpCode;
    logic        exMemWrite, exMemToReg, exRegWrite;
    logic [3:0]  exRc;
    logic [23:0] aluResult, writeData;
    logic        zeroFlag;

    execute_stage #(.DATA_W(24)) dut (
        .clk(clk), .rst(rst), .en(en),
        .opType(opType), .opCode(opCode),
        .memWrite(memWrite), .memToReg(memToReg), .regWrite(regWrite),
        .Rc(Rc), .srcA(srcA), .srcB(srcB), .storeData(storeData),
        .stall(stall), .exOpType(exOpType), .exOpCode(exOpCode),
        .exMemWrite(exMemWrite), .exMemToReg(exMemToReg), .exRegWrite(exRegWrite),
        .exRc(exRc), .aluResult(aluResult), .writeData(writeData),
        .zeroFlag(zeroFlag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] alu;
        logic [23:0] wd;
        logic [3:0]  rc;
        logic        rw, mw, mtr, zero, stall;
        logic        chk_rc, chk_wd;
    } exp_t;

    exp_t  q[$];
    string nq[$];
    exp_t  last;
    int    vectors = 0;
    int    miscompares = 0;

    // ------------------------------------------------------------------
    // Expected-value builders
    // ------------------------------------------------------------------
    function automatic exp_t res(input logic [23:0] alu, input logic [3:0] rc,
                                 input logic rw, input logic mw, input logic mtr,
                                 input logic [23:0] wd);
        exp_t e;
        e.alu = alu; e.wd = wd; e.rc = rc; e.rw = rw; e.mw = mw; e.mtr = mtr;
        e.zero = (alu == 24'h0); e.stall = 1'b0; e.chk_rc = 1'b1; e.chk_wd = 1'b1;
        return e;
    endfunction

    function automatic exp_t bub(input logic stl);
        exp_t e;
        e.alu = 24'h0; e.wd = 24'h0; e.rc = 4'h0; e.rw = 1'b0; e.mw = 1'b0; e.mtr = 1'b0;
        e.zero = 1'b1; e.stall = stl; e.chk_rc = 1'b0; e.chk_wd = 1'b0;
        return e;
    endfunction

    function automatic exp_t rst_e();
        exp_t e;
        e = bub(1'b0);
        e.chk_rc = 1'b1; e.chk_wd = 1'b1;
        return e;
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic set_op(input logic [1:0] t, input logic [3:0] c, input logic w,
                          input logic m2r, input logic r, input logic [3:0] d,
                          input logic [23:0] a, input logic [23:0] b, input logic [23:0] sd);
        opType = t; opCode = c; memWrite = w; memToReg = m2r; regWrite = r;
        Rc = d; srcA = a; srcB = b; storeData = sd;
    endtask

    task automatic tick(input exp_t e, input string n);
        q.push_back(e);
        nq.push_back(n);
        last = e;
        @(posedge clk);
        #1;
    endtask

    // One ALU-class instruction with a one-cycle expected result
    task automatic alu1(input logic [3:0] c, input logic [23:0] a, input logic [23:0] b,
                        input logic [23:0] expv, input string n);
        set_op(2'b00, c, 1'b0, 1'b0, 1'b1, 4'd2, a, b, 24'h000777);
        tick(res(expv, 4'd2, 1'b1, 1'b0, 1'b0, 24'h000777), n);
    endtask

    // Full multiply; optional en-low pause of plen cycles before iteration pat
    task automatic run_mul(input logic [23:0] a, input logic [23:0] b, input logic [3:0] rc,
                           input logic [23:0] prod, input int pat, input int plen,
                           input string n);
        exp_t e;
        en = 1'b1;
        set_op(2'b00, 4'd7, 1'b0, 1'b0, 1'b1, rc, a, b, 24'h0);
        tick(bub(1'b1), {n, "_accept"});
        // Presented while stalled: must be ignored
        set_op(2'b00, 4'd0, 1'b1, 1'b0, 1'b1, 4'd15, 24'h000001, 24'h000001, 24'h000005);
        for (int i = 1; i <= 24; i++) begin
            if (i == pat) begin
                en = 1'b0;
                for (int k = 0; k < plen; k++) tick(last, {n, "_paused"});
                en = 1'b1;
            end
            if (i < 24) begin
                tick(bub(1'b1), {n, "_run"});
            end else begin
                e = res(prod, rc, 1'b1, 1'b0, 1'b0, 24'h0);
                e.chk_wd = 1'b0;
                tick(e, {n, "_result"});
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: one snapshot compared after every clock edge
    // ------------------------------------------------------------------
    exp_t  m_e;
    string m_n;
    logic  m_bad;

    initial begin
        forever begin
            @(posedge clk);
            @(negedge clk);
            if (q.size() > 0) begin
                m_e = q.pop_front();
                m_n = nq.pop_front();
                vectors++;
                m_bad = (aluResult !== m_e.alu) || (exRegWrite !== m_e.rw) ||
                        (exMemWrite !== m_e.mw) || (exMemToReg !== m_e.mtr) ||
                        (zeroFlag !== m_e.zero) || (stall !== m_e.stall) ||
                        (m_e.chk_rc && (exRc !== m_e.rc)) ||
                        (m_e.chk_wd && (writeData !== m_e.wd));
                if (m_bad) begin
                    miscompares++;
                    $display("FAIL %s @%0t: got alu=%h rc=%h rw=%b mw=%b mtr=%b wd=%h zf=%b stall=%b ; want alu=%h rc=%h(chk %b) rw=%b mw=%b mtr=%b wd=%h(chk %b) zf=%b stall=%b",
                             m_n, $time, aluResult, exRc, exRegWrite, exMemWrite, exMemToReg,
                             writeData, zeroFlag, stall, m_e.alu, m_e.rc, m_e.chk_rc, m_e.rw,
                             m_e.mw, m_e.mtr, m_e.wd, m_e.chk_wd, m_e.zero, m_e.stall);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin
        rst = 1'b1;
        en  = 1'b1;
        set_op(2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 24'h0, 24'h0, 24'h0);
        #1;
        tick(rst_e(), "reset0");
        tick(rst_e(), "reset1");
        rst = 1'b0;

        // ADD 0xF + 1 -> 0x10, Rc=3
        set_op(2'b00, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3, 24'h00000F, 24'h000001, 24'h0);
        tick(res(24'h000010, 4'd3, 1'b1, 1'b0, 1'b0, 24'h0), "add");

        // en low in IDLE: everything holds
        en = 1'b0;
        set_op(2'b00, 4'd2, 1'b1, 1'b1, 1'b0, 4'd9, 24'h123456, 24'h0, 24'h0);
        tick(last, "idle_hold0");
        tick(last, "idle_hold1");
        en = 1'b1;

        alu1(4'd1, 24'h000005, 24'h000005, 24'h000000, "sub_zero");
        alu1(4'd5, 24'h000001, 24'h000017, 24'h800000, "sll23");
        alu1(4'd6, 24'h800000, 24'h000018, 24'h000000, "srl24");
        alu1(4'd6, 24'h800000, 24'h000004, 24'h080000, "srl4");
        alu1(4'd5, 24'h000001, 24'h00001F, 24'h000000, "sll31");
        alu1(4'd0, 24'hFFFFFF, 24'h000001, 24'h000000, "add_wrap");
        alu1(4'd1, 24'h000000, 24'h000001, 24'hFFFFFF, "sub_wrap");
        alu1(4'd2, 24'hF0F0F0, 24'hFF00FF, 24'hF000F0, "and");
        alu1(4'd3, 24'hF0F0F0, 24'h0F0000, 24'hFFF0F0, "or");
        alu1(4'd4, 24'hAAAAAA, 24'hFFFFFF, 24'h555555, "xor");
        alu1(4'd8, 24'h000000, 24'h123456, 24'h123456, "mov");

        // Undefined ALU op: result 0, regWrite/memWrite suppressed
        set_op(2'b00, 4'd10, 1'b1, 1'b0, 1'b1, 4'd4, 24'h000011, 24'h000022, 24'h000033);
        tick(res(24'h0, 4'd4, 1'b0, 1'b0, 1'b0, 24'h000033), "undef_op");

        // Memory class: address = A + B, store data forwarded
        set_op(2'b01, 4'd0, 1'b1, 1'b0, 1'b0, 4'd1, 24'h000100, 24'h000004, 24'h00ABCD);
        tick(res(24'h000104, 4'd1, 1'b0, 1'b1, 1'b0, 24'h00ABCD), "mem_store");

        // Load immediate
        set_op(2'b10, 4'd0, 1'b0, 1'b0, 1'b1, 4'd5, 24'h111111, 24'h00BEEF, 24'h0);
        tick(res(24'h00BEEF, 4'd5, 1'b1, 1'b0, 1'b0, 24'h0), "load_imm");

        // Bubble: controls are dropped even if asserted on input
        set_op(2'b11, 4'd0, 1'b1, 1'b1, 1'b1, 4'd6, 24'h000010, 24'h000020, 24'h000030);
        tick(bub(1'b0), "bubble");

        // Multiplies, the second issued right after the first completes
        run_mul(24'h000123, 24'h000045, 4'd7, 24'h004E6F, 0, 0, "mul_a");
        run_mul(24'hFFFFFF, 24'hFFFFFF, 4'd8, 24'h000001, 0, 0, "mul_ff");

        // Multiply with a 5-cycle freeze mid-run
        run_mul(24'h000ABC, 24'h000010, 4'd9, 24'h00ABC0, 11, 5, "mul_pause");

        // Reset at iteration 10 of a multiply abandons it
        set_op(2'b00, 4'd7, 1'b0, 1'b0, 1'b1, 4'd10, 24'h000123, 24'h000045, 24'h0);
        tick(bub(1'b1), "mul_rst_accept");
        for (int i = 1; i <= 9; i++) tick(bub(1'b1), "mul_rst_run");
        rst = 1'b1;
        tick(rst_e(), "mul_abort_reset");
        rst = 1'b0;
        set_op(2'b00, 4'd0, 1'b0, 1'b0, 1'b1, 4'd11, 24'h000020, 24'h000022, 24'h0);
        tick(res(24'h000042, 4'd11, 1'b1, 1'b0, 1'b0, 24'h0), "add_after_abort");
        set_op(2'b11, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 24'h0, 24'h0, 24'h0);
        tick(bub(1'b0), "tail_bubble");

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
